ram_arbiter: RTL



---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/arb_pick.sv | 33 +++
 rtl/ram_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-RAM arbiter.
package mem_arb_pkg;

    // Sequencing states of one RAM transaction.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    // Identity of the master that owns the current transaction.
    typedef enum logic {
        GRANT_M0 = 1'b0,
        GRANT_M1 = 1'b1
    } grant_t;

    // Largest supported RAM read latency.
    localparam int RD_LAT_MAX = 3;
    // Width of the master-1 starvation counter.
    localparam int STARVE_W   = 4;

endpackage

// File: rtl/arb_pick.sv
// Winner selection between the CPU MEM-stage port (m0) and the debug/loader
// port (m1). Pure combinational policy; the sequencing FSM only latches the
// result while idle.
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int CPU_PRIO   = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                m0_req,
    input  logic                m1_req,
    input  logic                last_grant,
    input  logic [STARVE_W-1:0] starve_cnt,
    output logic                winner
);

    // winner = 0 selects m0, winner = 1 selects m1.
    always_comb begin
        winner = 1'b0;
        if (CPU_PRIO != 0) begin
            // m0 has priority unless m1 has lost STARVE_MAX times in a row.
            if (m1_req && (!m0_req || (starve_cnt == STARVE_W'(STARVE_MAX)))) begin
                winner = 1'b1;
            end
        end else begin
            // Round-robin: on a tie the master that did not win last time goes.
            if (m1_req && (!m0_req || (last_grant == 1'b0))) begin
                winner = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single data RAM between the CPU MEM stage (m0) and the
// debug/program-loader port (m1). Each access becomes one RAM transaction:
// IDLE -> ISSUE -> (WAIT) -> (DONE) -> IDLE, with an ack pulse on completion.
//
// Handshake: a master raises mN_req with mN_we/mN_addr/mN_wdata and holds them
// stable until mN_ack, a single-cycle pulse (mN_rdata is valid with it for
// reads). Inputs are latched when the request wins in IDLE; later changes are
// ignored. A req still high in the IDLE cycle after ack is a new transaction.
module ram_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int CPU_PRIO   = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_re,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              cpu_stall,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int WAIT_W = $clog2(RD_LAT_MAX + 1);

    arb_state_t          state, state_nxt;
    grant_t              grant;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [STARVE_W-1:0] starve_cnt;
    logic                last_grant;
    logic [DATA_W-1:0]   m0_rdata_q, m1_rdata_q;
    logic                winner;
    logic                any_req;
    logic                capture;
    logic                ack_any;

    assign any_req = m0_req | m1_req;

    arb_pick #(
        .CPU_PRIO   (CPU_PRIO),
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .m0_req     (m0_req),
        .m1_req     (m1_req),
        .last_grant (last_grant),
        .starve_cnt (starve_cnt),
        .winner     (winner)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and RAM/ack strobes decoded from the current state.
    always_comb begin
        state_nxt = state;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        ack_any   = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (lat_we) begin
                    // Writes complete in the issue cycle itself.
                    ram_we    = 1'b1;
                    ack_any   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    ram_re = 1'b1;
                    if (RD_LAT == 0) begin
                        capture   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                ram_re = 1'b1;
                if (wait_cnt == WAIT_W'(1)) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ack_any   = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Grant latch, latency counter, starvation bookkeeping and read capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant      <= GRANT_M0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            last_grant <= 1'b1;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            if ((state == IDLE) && any_req) begin
                grant      <= grant_t'(winner);
                last_grant <= winner;
                lat_we     <= winner ? m1_we    : m0_we;
                lat_addr   <= winner ? m1_addr  : m0_addr;
                lat_wdata  <= winner ? m1_wdata : m0_wdata;
                if (winner) begin
                    starve_cnt <= '0;
                end else if (m1_req && (starve_cnt != {STARVE_W{1'b1}})) begin
                    starve_cnt <= starve_cnt + STARVE_W'(1);
                end
            end
            if ((state == ISSUE) && !lat_we) begin
                wait_cnt <= WAIT_W'(RD_LAT);
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - WAIT_W'(1);
            end
            if (capture) begin
                if (grant == GRANT_M1) begin
                    m1_rdata_q <= ram_rdata;
                end else begin
                    m0_rdata_q <= ram_rdata;
                end
            end
        end
    end

    assign ram_addr  = lat_addr;
    assign ram_wdata = lat_wdata;
    assign m0_ack    = ack_any && (grant == GRANT_M0);
    assign m1_ack    = ack_any && (grant == GRANT_M1);
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign cpu_stall = m0_req & ~m0_ack;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule
